// File: rtl/branch_pkg.sv
// Shared opcode/condition encodings, operation classes and BHT counter type
// for the branch resolve unit.
package branch_pkg;

    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        OP_OTHER,
        OP_BRANCH,
        OP_JUMP
    } op_class_e;

    typedef logic [1:0] bht_ctr_t;
    localparam bht_ctr_t BHT_CTR_RESET = 2'b01;

    function automatic op_class_e decode_op(input logic [4:0] opcode);
        case (opcode)
            OPC_BRANCH:        return OP_BRANCH;
            OPC_JAL, OPC_JALR: return OP_JUMP;
            default:           return OP_OTHER;
        endcase
    endfunction

    // Two-bit saturating step: never wraps past 00 or 11.
    function automatic bht_ctr_t bht_ctr_next(input bht_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_if.sv
// Resolve request, registered resolve results and fetch-side lookup of the
// branch resolve unit.
interface branch_resolve_bht_if #(
    parameter int XLEN     = 32,
    parameter int PC_WIDTH = 32
);
    logic                flush_in;
    logic                valid_in;
    logic [4:0]          opcode_6_to_2_in;
    logic [2:0]          funct3_in;
    logic [XLEN-1:0]     rs1_in;
    logic [XLEN-1:0]     rs2_in;
    logic [PC_WIDTH-1:0] pc_in;
    logic                pred_taken_in;
    logic [PC_WIDTH-1:0] lookup_pc_in;
    logic                lookup_taken_out;
    logic                valid_out;
    logic                branch_taken_out;
    logic                mispredict_out;
    logic                illegal_out;

    modport master (
        output flush_in, valid_in, opcode_6_to_2_in, funct3_in, rs1_in, rs2_in,
               pc_in, pred_taken_in, lookup_pc_in,
        input  lookup_taken_out, valid_out, branch_taken_out, mispredict_out,
               illegal_out
    );

    modport slave (
        input  flush_in, valid_in, opcode_6_to_2_in, funct3_in, rs1_in, rs2_in,
               pc_in, pred_taken_in, lookup_pc_in,
        output lookup_taken_out, valid_out, branch_taken_out, mispredict_out,
               illegal_out
    );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition evaluator: full-width signed/unsigned compares
// selected by funct3; the two unused encodings are flagged illegal.
module branch_cond
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken,
    output logic            illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolve unit with one-cycle registered results and an optional
// 2-bit-counter branch history table, built only when BRANCH_BHT_EN is defined.
module branch_resolve_bht
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PC_WIDTH  = 32,
    parameter int BHT_DEPTH = 16
) (
    input logic                clk_in,
    input logic                reset_in,
    branch_resolve_bht_if.slave bus
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    op_class_e op_class;
    logic      cond_taken;
    logic      cond_illegal;
    logic      accept;
    logic      res_taken;
    logic      res_illegal;
    logic      bht_we;
    logic      valid_q;
    logic      taken_q;
    logic      mispredict_q;
    logic      illegal_q;
    logic      unused_bits;

    branch_cond #(
        .XLEN(XLEN)
    ) u_cond (
        .funct3 (bus.funct3_in),
        .rs1    (bus.rs1_in),
        .rs2    (bus.rs2_in),
        .taken  (cond_taken),
        .illegal(cond_illegal)
    );

    always_comb begin
        op_class    = decode_op(bus.opcode_6_to_2_in);
        accept      = bus.valid_in & ~bus.flush_in;
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (op_class)
            OP_BRANCH: begin
                res_taken   = cond_taken;
                res_illegal = cond_illegal;
            end
            OP_JUMP:   res_taken = 1'b1;
            default:   ;
        endcase
        bht_we = accept & (op_class == OP_BRANCH) & ~cond_illegal;
    end

    // Every result bit is gated by accept so nothing leaks out while valid_out is low.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            valid_q      <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            valid_q      <= accept;
            taken_q      <= accept & res_taken;
            mispredict_q <= accept & (res_taken != bus.pred_taken_in);
            illegal_q    <= accept & res_illegal;
        end
    end

    assign bus.valid_out        = valid_q;
    assign bus.branch_taken_out = taken_q;
    assign bus.mispredict_out   = mispredict_q;
    assign bus.illegal_out      = illegal_q;

`ifdef BRANCH_BHT_EN
    bht_ctr_t         bht [BHT_DEPTH];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] look_idx;

    assign upd_idx  = bus.pc_in[2 +: IDX_W];
    assign look_idx = bus.lookup_pc_in[2 +: IDX_W];

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_CTR_RESET;
            end
        end else if (bht_we) begin
            bht[upd_idx] <= bht_ctr_next(bht[upd_idx], cond_taken);
        end
    end

    // Read straight from the array: a same-cycle update is not forwarded.
    assign bus.lookup_taken_out = bht[look_idx][1];
`else
    assign bus.lookup_taken_out = 1'b0;
`endif

    assign unused_bits = ^{bus.pc_in, bus.lookup_pc_in, bht_we};

endmodule

// File: doc/branch_resolve_bht.md
BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: operand width in bits.
REQ-002 The block SHALL have parameter PC_WIDTH, default 32: program-counter width in bits.
REQ-003 The block SHALL have parameter BHT_DEPTH, default 16: number of branch-history entries; power of two, >= 2.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_in, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port flush_in, input, 1 bit: discards the instruction presented this cycle.
REQ-007 The block SHALL have port valid_in, input, 1 bit: resolve request valid.
REQ-008 The block SHALL have port opcode_6_to_2_in, input, 5 bits: instruction opcode bits [6:2].
REQ-009 The block SHALL have port funct3_in, input, 3 bits: branch condition selector.
REQ-010 The block SHALL have ports rs1_in and rs2_in, input, XLEN bits each: compare operands.
REQ-011 The block SHALL have port pc_in, input, PC_WIDTH bits: PC of the resolving instruction.
REQ-012 The block SHALL have port pred_taken_in, input, 1 bit: prediction made at fetch for this instruction.
REQ-013 The block SHALL have port lookup_pc_in, input, PC_WIDTH bits: fetch PC for prediction.
REQ-014 The block SHALL have port lookup_taken_out, output, 1 bit: prediction for lookup_pc_in (combinational).
REQ-015 The block SHALL have ports valid_out, branch_taken_out, mispredict_out and illegal_out, output, 1 bit each: registered resolve results.

Function
REQ-016 Opcodes SHALL decode as BRANCH 11000, JAL 11011, JALR 11001; every other value is non-control.
REQ-017 Conditions SHALL be: 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; all compares span the full XLEN.
REQ-018 On BRANCH, funct3 010/011 SHALL give taken=0, illegal=1.
REQ-019 JAL/JALR SHALL give taken=1; non-control SHALL give taken=0; illegal SHALL be 0 for both.
REQ-020 Resolve latency SHALL be exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N.
REQ-021 valid_out SHALL equal valid_in & ~flush_in registered; the other outputs are 0 whenever valid_out is 0.
REQ-022 mispredict_out SHALL equal valid_out & (branch_taken_out != registered pred_taken_in).
REQ-023 The BHT SHALL hold BHT_DEPTH 2-bit saturating counters indexed by pc[2 +: log2(BHT_DEPTH)].
REQ-024 lookup_taken_out SHALL be counter[index(lookup_pc_in)][1].
REQ-025 An accepted, legal BRANCH SHALL update its counter at the same edge: taken -> +1 saturating at 11; not taken -> -1 saturating at 00.
REQ-026 JAL, JALR, illegal, non-control and flushed instructions SHALL NOT update the BHT.
REQ-027 Lookup and update to the same index in one cycle SHALL return the pre-update value (no bypass).
REQ-028 The block SHALL contain no latches; every combinational output SHALL be assigned on all paths.

Reset
REQ-029 Asserting reset_in SHALL immediately clear valid_out, branch_taken_out, mispredict_out and illegal_out to 0, and set every counter to 01 (weakly not-taken).
REQ-030 Reset asserted mid-operation SHALL discard the in-flight result; the first valid_out SHALL occur one edge after the first accepted valid_in following deassertion.

Configuration
REQ-031 With macro BRANCH_BHT_EN defined, the BHT SHALL be built as specified.
REQ-032 Without BRANCH_BHT_EN, the block SHALL have no counter storage, SHALL tie lookup_taken_out to 0, and all resolve behaviour SHALL be unchanged.

Structure
REQ-033 A shared package branch_pkg SHALL hold the opcode constants, the funct3 encodings and the 2-bit counter type with its reset value.
REQ-034 The condition evaluator SHALL be a combinational sub-module branch_cond (funct3, rs1, rs2 -> taken, illegal); the registers and BHT live in the top.

Verification
REQ-035 BEQ rs1=rs2=0x5, pred=0 -> next cycle valid=1, taken=1, mispredict=1; counter 01->10.
REQ-036 BLT rs1=0xFFFFFFFF, rs2=0x1 -> taken=1; BLTU with the same operands -> taken=0.
REQ-037 Four taken BRANCH at pc=0x40 -> counter saturates at 11; lookup_pc_in=0x40 -> lookup_taken_out=1; pc=0x80 aliases to the same entry with BHT_DEPTH=16.
REQ-038 valid_in=1 with flush_in=1, BNE taken -> valid_out=0 and the counter is unchanged.
REQ-039 BRANCH funct3=010 -> illegal_out=1, taken=0, no BHT update; JALR pred=1 -> taken=1, mispredict=0.
REQ-040 Reset pulsed between edges with an in-flight result -> all outputs 0 immediately and every counter reads 01.
